// File: rtl/end_screen_renderer.sv
// End-of-game screen renderer: win/lose glyph over a gradient background,
// per-frame fade-in and a blinking decimal score converted by double-dabble.
module end_screen_renderer #(
  parameter int CENTER_X     = 320,
  parameter int CENTER_Y     = 240,
  parameter int CELL_SHIFT   = 4,
  parameter int SCORE_W      = 14,
  parameter int SCORE_DIGITS = 3,
  parameter int DIGIT_SHIFT  = 2,
  parameter int DIGIT_Y      = 352,
  parameter int FADE_INC     = 8,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               is_won,
  input  logic               is_lost,
  input  logic [SCORE_W-1:0] score,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  output logic [7:0]         VGA_R,
  output logic [7:0]         VGA_G,
  output logic [7:0]         VGA_B,
  output logic               busy
);

  localparam int BCD_W       = 4 * SCORE_DIGITS;
  localparam int DIG_PX      = 5 << DIGIT_SHIFT;
  localparam int DIG_H       = 7 << DIGIT_SHIFT;
  localparam int STRIP_X0    = CENTER_X - (SCORE_DIGITS * DIG_PX) / 2;
  localparam int SCORE_LIMIT = 10 ** SCORE_DIGITS;
  localparam int CNT_W       = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam int BLINK_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic signed [11:0] CX_S     = 12'(CENTER_X);
  localparam logic signed [11:0] CY_S     = 12'(CENTER_Y);
  localparam logic signed [11:0] X0_S     = 12'(STRIP_X0);
  localparam logic signed [11:0] Y0_S     = 12'(DIGIT_Y);
  localparam logic signed [11:0] DIG_PX_S = 12'(DIG_PX);
  localparam logic signed [11:0] DIG_H_S  = 12'(DIG_H);

  typedef enum logic [1:0] {IDLE, CONVERT, FADE, SHOW} state_t;

  function automatic logic [7:0] sat_sub8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : 8'd0;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [7:0] fade_scale(input logic [7:0] c, input logic [7:0] f);
    logic [15:0] p;
    p = {8'd0, c} * {8'd0, f};
    return p[15:8];
  endfunction

  function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd,
                                                   input logic bit_in);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < SCORE_DIGITS; i++)
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    return {adj[BCD_W-2:0], bit_in};
  endfunction

  // Segment order {a,b,c,d,e,f,g}
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic seg_cell(input logic [6:0] s, input logic [2:0] col,
                                    input logic [2:0] row);
    return (s[6] && row == 3'd0) ||
           (s[0] && row == 3'd3) ||
           (s[3] && row == 3'd6) ||
           (s[5] && col == 3'd3 && row <= 3'd3) ||
           (s[1] && col == 3'd0 && row <= 3'd3) ||
           (s[4] && col == 3'd3 && row >= 3'd3) ||
           (s[2] && col == 3'd0 && row >= 3'd3);
  endfunction

  state_t             state;
  logic               won_q;
  logic [SCORE_W-1:0] bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [7:0]         fade_q;
  logic [BLINK_W-1:0] blink_q;
  logic               vis_q;

  logic [SCORE_W-1:0] score_sat;
  logic [7:0]         fade_nxt;

  // Clamping before conversion keeps the BCD register at SCORE_DIGITS digits
  assign score_sat = (32'(score) >= 32'(SCORE_LIMIT)) ? SCORE_W'(SCORE_LIMIT - 1) : score;
  assign fade_nxt  = sat_add8(fade_q, 8'(FADE_INC));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      won_q   <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      fade_q  <= 8'd0;
      blink_q <= '0;
      vis_q   <= 1'b0;
    end else if (state == IDLE) begin
      if (is_won || is_lost) begin
        won_q <= is_won;
        bin_q <= score_sat;
        bcd_q <= '0;
        cnt_q <= '0;
        busy  <= 1'b1;
        state <= CONVERT;
      end
    end else if (!is_won && !is_lost) begin
      state   <= IDLE;
      busy    <= 1'b0;
      fade_q  <= 8'd0;
      blink_q <= '0;
    end else begin
      case (state)
        CONVERT: begin
          bcd_q <= dabble_step(bcd_q, bin_q[SCORE_W-1]);
          bin_q <= bin_q << 1;
          if (cnt_q == CNT_W'(SCORE_W - 1)) begin
            state  <= FADE;
            busy   <= 1'b0;
            fade_q <= 8'd0;
            vis_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FADE: begin
          if (frame_tick) begin
            fade_q <= fade_nxt;
            if (fade_nxt == 8'hFF) begin
              state   <= SHOW;
              blink_q <= '0;
              vis_q   <= 1'b1;
            end
          end
        end
        SHOW: begin
          if (frame_tick) begin
            if (blink_q == BLINK_W'(BLINK_FRAMES - 1)) begin
              blink_q <= '0;
              vis_q   <= ~vis_q;
            end else begin
              blink_q <= blink_q + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0: pixel classification from DrawX/DrawY
  logic signed [11:0] dx_p0, dy_p0, adx_p0;
  logic               glyph_p0;

  always_comb begin
    dx_p0    = (CX_S - $signed({2'b00, DrawX})) >>> CELL_SHIFT;
    dy_p0    = (CY_S - $signed({2'b00, DrawY})) >>> CELL_SHIFT;
    adx_p0   = dx_p0[11] ? -dx_p0 : dx_p0;
    glyph_p0 = (dy_p0 == 12'sd2 && dx_p0 == 12'sd0) ||
               (dy_p0 == 12'sd1 && adx_p0 <= 12'sd1) ||
               (dy_p0 == 12'sd0 && adx_p0 <= 12'sd4) ||
               (dy_p0 >= -12'sd3 && dy_p0 <= -12'sd1 && adx_p0 <= 12'sd5);
  end

  logic signed [11:0] rel_x_p0, rel_y_p0, lo_p0, off_p0;
  logic [2:0]         col_p0, row_p0;
  logic [3:0]         dval_p0;
  logic               lead_p0, digit_p0;

  always_comb begin
    rel_x_p0 = $signed({2'b00, DrawX}) - X0_S;
    rel_y_p0 = $signed({2'b00, DrawY}) - Y0_S;
    lo_p0    = 12'sd0;
    off_p0   = 12'sd0;
    col_p0   = 3'd0;
    row_p0   = 3'd0;
    dval_p0  = 4'd0;
    lead_p0  = 1'b1;
    digit_p0 = 1'b0;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      dval_p0 = bcd_q[4*(SCORE_DIGITS-1-i) +: 4];
      lead_p0 = lead_p0 & (dval_p0 == 4'd0);
      lo_p0   = 12'(i * DIG_PX);
      if (rel_x_p0 >= lo_p0 && rel_x_p0 < lo_p0 + DIG_PX_S &&
          rel_y_p0 >= 12'sd0 && rel_y_p0 < DIG_H_S) begin
        off_p0 = rel_x_p0 - lo_p0;
        col_p0 = 3'(off_p0 >>> DIGIT_SHIFT);
        row_p0 = 3'(rel_y_p0 >>> DIGIT_SHIFT);
        // Leading zeros go dark, but the units digit always shows
        if (!(lead_p0 && i != SCORE_DIGITS - 1) && col_p0 != 3'd4 &&
            seg_cell(seg_decode(dval_p0), col_p0, row_p0))
          digit_p0 = 1'b1;
      end
    end
    digit_p0 = digit_p0 & vis_q;
  end

  logic       vld_p0;
  logic [7:0] r_p0, g_p0, b_p0;

  always_comb begin
    vld_p0 = (state == FADE) || (state == SHOW);
    if (glyph_p0) begin
      r_p0 = 8'hFF; g_p0 = 8'hFF; b_p0 = 8'hFF;
    end else if (digit_p0) begin
      r_p0 = 8'hFF; g_p0 = 8'hFF; b_p0 = 8'h00;
    end else if (won_q) begin
      r_p0 = sat_sub8(8'h7F, {1'b0, DrawX[9:3]});
      g_p0 = 8'hB0;
      b_p0 = 8'h8A;
    end else begin
      r_p0 = 8'hFF;
      g_p0 = 8'h7A;
      b_p0 = sat_sub8(8'h29, {1'b0, DrawY[9:3]});
    end
    if (state == FADE) begin
      r_p0 = fade_scale(r_p0, fade_q);
      g_p0 = fade_scale(g_p0, fade_q);
      b_p0 = fade_scale(b_p0, fade_q);
    end
    if (!vld_p0) begin
      r_p0 = 8'd0; g_p0 = 8'd0; b_p0 = 8'd0;
    end
  end

  // Stage p1: registered VGA outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      VGA_R <= 8'd0;
      VGA_G <= 8'd0;
      VGA_B <= 8'd0;
    end else begin
      VGA_R <= r_p0;
      VGA_G <= g_p0;
      VGA_B <= b_p0;
    end
  end

endmodule

// File: tb/tb_end_screen_renderer.sv
// Self-checking bench for end_screen_renderer: pixel scoreboard, font-table
// reference model, conversion timing, fade, blink and asynchronous reset.
module tb_end_screen_renderer;

  logic        Clk = 1'b0;
  logic        Reset, frame_tick, is_won, is_lost;
  logic [13:0] score;
  logic [9:0]  DrawX, DrawY;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        busy;

  end_screen_renderer dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .is_won(is_won),
    .is_lost(is_lost), .score(score), .DrawX(DrawX), .DrawY(DrawY),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] exp;
    string       name;
    int          x;
    int          y;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    int          x;
    int          y;
    logic [23:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[14];

  // Reference model state
  bit m_won;
  int m_dig[3];
  bit m_vis;
  int m_fade;
  bit m_scaled;

  // 7 rows of 4 cells, row 0 in the top nibble, column 0 in the nibble MSB
  function automatic logic [27:0] font(input int d);
    case (d)
      0: return 28'hF99999F;
      1: return 28'h1111111;
      2: return 28'hF11F88F;
      3: return 28'hF11F11F;
      4: return 28'h999F111;
      5: return 28'hF88F11F;
      6: return 28'hF88F99F;
      7: return 28'hF111111;
      8: return 28'hF99F99F;
      9: return 28'hF99F11F;
      default: return 28'h0;
    endcase
  endfunction

  function automatic logic [23:0] model_pix(input int x, input int y);
    int dx, dy, adx, r, g, b, rx, ry, i, col, row;
    logic [27:0] f;
    bit lit, blank;
    dx  = (320 - x) >>> 4;
    dy  = (240 - y) >>> 4;
    adx = (dx < 0) ? -dx : dx;
    lit = 0;
    if ((dy == 2 && dx == 0) || (dy == 1 && adx <= 1) || (dy == 0 && adx <= 4) ||
        (dy >= -3 && dy <= -1 && adx <= 5)) begin
      r = 255; g = 255; b = 255;
    end else begin
      rx = x - 290;
      ry = y - 352;
      if (rx >= 0 && rx < 60 && ry >= 0 && ry < 28 && m_vis) begin
        i     = rx / 20;
        col   = (rx % 20) / 4;
        row   = ry / 4;
        blank = (i == 0 && m_dig[0] == 0) || (i == 1 && m_dig[0] == 0 && m_dig[1] == 0);
        f     = font(m_dig[i]);
        if (col < 4 && !blank) lit = f[27 - row*4 - col];
      end
      if (lit) begin
        r = 255; g = 255; b = 0;
      end else if (m_won) begin
        r = 127 - (x >> 3); if (r < 0) r = 0;
        g = 176; b = 138;
      end else begin
        r = 255; g = 122;
        b = 41 - (y >> 3); if (b < 0) b = 0;
      end
    end
    if (m_scaled) begin
      r = (r * m_fade) >> 8;
      g = (g * m_fade) >> 8;
      b = (b * m_fade) >> 8;
    end
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  task automatic compare(input logic [23:0] got, input logic [23:0] exp,
                         input string name, input int x, input int y);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at (%0d,%0d): got %06h expected %06h", name, x, y, got, exp);
    end
  endtask

  task automatic check_bit(input logic got, input logic exp, input string name);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic drive_pix(input int x, input int y, input logic [23:0] exp,
                           input string name);
    sb_t e;
    DrawX = 10'(x);
    DrawY = 10'(y);
    sb_q.push_back('{exp, name, x, y});
    @(posedge Clk); #1;
    e = sb_q.pop_front();
    compare({VGA_R, VGA_G, VGA_B}, e.exp, e.name, e.x, e.y);
  endtask

  task automatic model_chk(input int x, input int y, input string name);
    drive_pix(x, y, model_pix(x, y), name);
  endtask

  task automatic scan_digits(input string name);
    for (int i = 0; i < 3; i++)
      for (int col = 0; col < 5; col++)
        for (int row = 0; row < 7; row++)
          model_chk(290 + i*20 + col*4 + 1, 352 + row*4 + 2, name);
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1;
      @(posedge Clk); #1;
      frame_tick = 1'b0;
    end
  endtask

  // Counts busy cycles of one conversion; outputs must stay black meanwhile
  task automatic run_convert(input string name);
    int highs = 0;
    bit seen = 0, done = 0, lit = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(posedge Clk); #1;
      if (busy) begin
        highs++;
        seen = 1;
        if ({VGA_R, VGA_G, VGA_B} !== 24'h0) lit = 1;
      end else if (seen) begin
        done = 1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: busy did not complete within 64 cycles (seen=%0d)", name, seen);
    end else if (highs != 14) begin
      errors++;
      $display("FAIL %s: busy high %0d cycles, expected 14", name, highs);
    end
    check_bit(lit, 1'b0, {name, "_black_while_busy"});
  endtask

  initial begin
    vecs[0]  = '{0,   0,   24'hFF7A29, "lost_bg_origin"};
    vecs[1]  = '{0,   400, 24'hFF7A00, "lost_bg_clamp"};
    vecs[2]  = '{320, 240, 24'hFFFFFF, "glyph_centre"};
    vecs[3]  = '{320, 208, 24'hFFFFFF, "glyph_dy2"};
    vecs[4]  = '{320, 192, 24'hFF7A11, "glyph_dy3_off"};
    vecs[5]  = '{304, 208, 24'hFF7A0F, "glyph_dy2_dx1_off"};
    vecs[6]  = '{336, 216, 24'hFFFFFF, "glyph_dy1_dxm1"};
    vecs[7]  = '{337, 216, 24'hFF7A0E, "glyph_dy1_dxm2_off"};
    vecs[8]  = '{256, 240, 24'hFFFFFF, "glyph_dy0_dx4"};
    vecs[9]  = '{240, 240, 24'hFF7A0B, "glyph_dy0_dx5_off"};
    vecs[10] = '{400, 260, 24'hFFFFFF, "glyph_dym2_dxm5"};
    vecs[11] = '{401, 260, 24'hFF7A09, "glyph_dym2_dxm6_off"};
    vecs[12] = '{320, 288, 24'hFFFFFF, "glyph_dym3"};
    vecs[13] = '{320, 289, 24'hFF7A05, "glyph_dym4_off"};

    Reset = 1'b1; frame_tick = 1'b0; is_won = 1'b0; is_lost = 1'b1;
    score = 14'd42; DrawX = 10'd0; DrawY = 10'd0;
    repeat (3) @(posedge Clk);
    #1;
    compare({VGA_R, VGA_G, VGA_B}, 24'h0, "reset_vga", 0, 0);
    check_bit(busy, 1'b0, "reset_busy");

    // Idle after release: black everywhere, never busy
    is_lost = 1'b0;
    Reset   = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k % 5 == 4) tick(1);
      drive_pix($urandom_range(0, 639), $urandom_range(0, 479), 24'h0, "idle_black");
      check_bit(busy, 1'b0, "idle_busy");
    end

    // Lost, score 42
    is_lost = 1'b1; score = 14'd42; DrawX = 10'd0; DrawY = 10'd0;
    run_convert("conv_lost42");
    m_won = 0; m_dig = '{0, 4, 2}; m_vis = 1; m_scaled = 1; m_fade = 0;
    drive_pix(0, 0, 24'h000000, "fade0_black");
    tick(16);
    m_fade = 128;
    drive_pix(0, 0, 24'h7F3D14, "lost_fade128");
    tick(15);
    m_fade = 248;
    model_chk(0, 0, "lost_fade248");
    tick(1);
    m_scaled = 0;
    for (int k = 0; k < 14; k++) drive_pix(vecs[k].x, vecs[k].y, vecs[k].exp, vecs[k].name);
    scan_digits("digits_42");

    // Dropping both flags returns to idle one cycle later
    is_lost = 1'b0;
    drive_pix(0, 0, 24'hFF7A29, "drop_last_show");
    drive_pix(0, 0, 24'h000000, "drop_idle");

    // Won, score 105, checked mid-fade and in SHOW
    is_won = 1'b1; score = 14'd105;
    run_convert("conv_won105");
    m_won = 1; m_dig = '{1, 0, 5}; m_scaled = 1;
    tick(16);
    m_fade = 128;
    drive_pix(0, 0, 24'h3F5845, "won_fade128_bg");
    drive_pix(320, 240, 24'h7F7F7F, "won_fade128_glyph");
    drive_pix(331, 353, 24'h7F7F00, "won_fade128_digit");
    tick(16);
    m_scaled = 0;
    drive_pix(1023, 0, 24'h00B08A, "won_bg_clamp");
    scan_digits("digits_105");
    is_won = 1'b0;
    drive_pix(0, 0, 24'h7FB08A, "drop_won_last");
    drive_pix(0, 0, 24'h000000, "drop_won_idle");

    // Both flags, saturated score, blink
    is_won = 1'b1; is_lost = 1'b1; score = 14'd1500;
    run_convert("conv_sat");
    m_won = 1; m_dig = '{9, 9, 9}; m_vis = 1;
    tick(32);
    m_scaled = 0;
    drive_pix(0, 0, 24'h7FB08A, "both_won_bg");
    scan_digits("digits_999");
    is_won = 1'b0; score = 14'd0;
    drive_pix(0, 0, 24'h7FB08A, "ignore_change_bg");
    drive_pix(291, 353, 24'hFFFF00, "ignore_change_digit");
    tick(29);
    drive_pix(291, 353, 24'hFFFF00, "blink_f29");
    tick(1);
    m_vis = 0;
    drive_pix(291, 353, 24'h5BB08A, "blink_f30");
    scan_digits("digits_blank");
    tick(29);
    drive_pix(291, 353, 24'h5BB08A, "blink_f59");
    tick(1);
    m_vis = 1;
    drive_pix(291, 353, 24'hFFFF00, "blink_f60");
    is_lost = 1'b0;
    repeat (2) @(posedge Clk);
    #1;

    // Asynchronous reset mid-conversion and mid-fade
    is_lost = 1'b1; score = 14'd7; DrawX = 10'd0; DrawY = 10'd0;
    repeat (5) @(posedge Clk);
    #3 Reset = 1'b1;
    #1;
    check_bit(busy, 1'b0, "rst_mid_conv_busy");
    compare({VGA_R, VGA_G, VGA_B}, 24'h0, "rst_mid_conv_vga", 0, 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    run_convert("conv_after_rst");
    m_won = 0; m_dig = '{0, 0, 7}; m_vis = 1; m_scaled = 1;
    tick(20);
    m_fade = 160;
    model_chk(0, 0, "lost_fade160");
    #3 Reset = 1'b1;
    #1;
    compare({VGA_R, VGA_G, VGA_B}, 24'h0, "rst_mid_fade_vga", 0, 0);
    check_bit(busy, 1'b0, "rst_mid_fade_busy");
    @(posedge Clk); #1;
    compare({VGA_R, VGA_G, VGA_B}, 24'h0, "rst_hold_vga", 0, 0);
    Reset = 1'b0;
    run_convert("conv_after_rst2");
    m_fade = 0;
    drive_pix(0, 0, 24'h000000, "fade_restart_black");
    tick(32);
    m_scaled = 0;
    scan_digits("digits_7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
